i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
Register-access master that sits directly upstream of the I2C byte driver. It accepts one register read or write command per transaction from system logic. It expands the command into the driver's byte-level handshake sequence: ena, start_transfer, r_start, stop_transfer, rw, data_wr. It returns read data and NACK/timeout status on a single-cycle response strobe.

Parameters:
TIMEOUT_CYC, 2_000_000, clk cycles allowed per driver step before abort (40 ms at 50 MHz)
TO_W, 22, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; asynchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid & cmd_ready
cmd_rd  in  1  1 = register read, 0 = register write
cmd_dev  in  7  7-bit device address
cmd_reg  in  8  register index
cmd_wdata  in  8  write data; ignored on read
rsp_valid  out  1  one-cycle pulse at end of transaction
rsp_rdata  out  8  read byte; valid with rsp_valid on successful read, else 0
rsp_nack  out  1  slave NACKed a byte, valid with rsp_valid
rsp_timeout  out  1  driver step exceeded TIMEOUT_CYC, valid with rsp_valid
drv_ena  out  1  to driver ena
drv_rw  out  1  to driver rw
drv_data_wr  out  8  to driver data_wr
drv_start_transfer  out  1  to driver start_transfer
drv_stop_transfer  out  1  to driver stop_transfer
drv_r_start  out  1  to driver r_start
drv_ready  in  1  from driver ready
drv_busy  in  1  from driver busy
drv_ack_err  in  1  from driver ack_err; sticky until next START
drv_data_rd  in  8  from driver data_rd

Behaviour:
- Reset values:
  - all drv_* outputs 0
  - rsp_* outputs 0
  - cmd_ready 1
  - state IDLE
  - timeout counter 0
- The driver runs on its own slow data clock, so every request is level-held:
  - assert the request and hold it until drv_busy=1 is seen (accepted);
  - deassert it, then wait for drv_ready=1 & drv_busy=0 (step done).
- Command latch: on cmd_valid & cmd_ready, latch all cmd_* fields and set byte list:
  - write: [{dev,0}, reg, wdata]
  - read: [{dev,0}, reg], RSTART, [{dev,1}], RDBYTE
- drv_rw:
  - 0 for all write bytes and address bytes;
  - 1 only for RDBYTE;
  - held stable from request until step done.
- States:
  - IDLE: cmd_ready=1; on accept go to OPEN.
  - OPEN: drv_ena=1. Wait for drv_busy=1, then for drv_ready=1 (START issued). Go to SEND.
  - SEND: drive drv_data_wr, drv_rw, drv_start_transfer=1. On drv_busy=1 deassert start and go to WAIT_DONE.
  - WAIT_DONE: on done, sample drv_ack_err.
    - ack_err=1 and byte was not RDBYTE: set nack flag, go to CLOSE.
    - otherwise go to next list item; end of list goes to CLOSE.
    - RDBYTE completion captures drv_data_rd into rsp_rdata register.
  - RSTART: drv_r_start=1 until drv_busy=1, then wait done, continue with list.
  - CLOSE: drv_ena=0, drv_stop_transfer=1 until drv_busy=1, then wait drv_ready=1. Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; return to IDLE.
- drv_ena behaviour:
  - drv_ena stays 1 from OPEN through the last byte.
  - drv_ena drops in CLOSE so the driver returns to system_ready after STOP rather than re-STARTing.
- Read ACK: the driver ACKs the read byte. This is accepted for single-byte reads; no master NACK is generated.
- Timeout:
  - counter clears on every state change and increments while waiting.
  - Reaching TIMEOUT_CYC sets the timeout flag, clears all drv_* requests and drv_ena, and goes to RESP without STOP.
  - rsp_nack=0 on timeout.
- No new command is accepted until RESP has been emitted.
- cmd_valid while busy is ignored (cmd_ready=0); there is no queueing.
- rst mid-transaction: all outputs return to reset values immediately. No STOP is issued; the driver is reset from the same rst.

Decomposition:
- Package i2c_pkg holds:
  - state encoding localparams;
  - item codes: ITEM_BYTE, ITEM_RSTART, ITEM_RDBYTE;
  - DIR_WR=0, DIR_RD=1;
  - default TIMEOUT_CYC.
- One sub-module, i2c_step_handshake, is natural: hold-request/await-busy/await-ready plus timeout counter. It is instantiated once and shared by all states. The sequencer FSM remains in the top.

Test Plan:
1. Write dev=0x1E reg=0x02 wdata=0x00, slave ACKs all:
   - bus shows START, 0x3C, 0x02, 0x00, STOP;
   - rsp_valid pulse with nack=0, timeout=0;
   - cmd_ready returns 1 the next cycle.
2. Read dev=0x1E reg=0x0A, slave returns 0x48:
   - bus shows START, 0x3C, 0x0A, Sr, 0x3D, read, STOP;
   - rsp_rdata=0x48, nack=0.
3. Write to absent dev=0x50 (address NACK):
   - no reg or data bytes on bus, STOP issued;
   - rsp_nack=1, rsp_rdata=0x00.
4. Driver model holds drv_busy=0 forever, TIMEOUT_CYC=1000:
   - rsp_valid with rsp_timeout=1 at 1000 cycles ±2 after the step began;
   - all drv_* outputs 0.
5. Assert rst during the data byte of a write:
   - all outputs at reset values within the same cycle;
   - a subsequent read command completes normally.
6. cmd_valid held high continuously with alternating commands:
   - exactly one rsp_valid per accepted command;
   - no command accepted while cmd_ready=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state, item and direction encodings for the I2C register sequencer.
package i2c_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_SEND, S_RSTART, S_WAIT_DONE, S_CLOSE, S_RESP
    } state_t;
    localparam logic [1:0] ITEM_BYTE   = 2'd0;
    localparam logic [1:0] ITEM_RSTART = 2'd1;
    localparam logic [1:0] ITEM_RDBYTE = 2'd2;
    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;
    localparam int TIMEOUT_CYC_DEF = 2_000_000;
    // read list: addr, reg, Sr, addr+R, read byte; write list: addr, reg, data
    function automatic logic [1:0] item_kind(input logic rd, input logic [2:0] idx);
        return (rd && idx == 3'd2) ? ITEM_RSTART : (rd && idx == 3'd4) ? ITEM_RDBYTE : ITEM_BYTE;
    endfunction
endpackage

// File: rtl/i2c_step_handshake.sv
// i2c_step_handshake: level-held request until busy, then wait ready & ~busy, with per-step timeout.
module i2c_step_handshake #(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int TO_W = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    input  logic drv_busy,
    input  logic drv_ready,
    output logic req,
    output logic accepted,
    output logic done,
    output logic timeout
);
    logic wait_q;
    logic [TO_W-1:0] cnt_q;
    assign req      = active & ~wait_q;
    assign accepted = req & drv_busy;
    assign done     = active & wait_q & drv_ready & ~drv_busy;
    assign timeout  = active & ~accepted & ~done & (cnt_q == TO_W'(TIMEOUT_CYC - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            wait_q <= active & ~done & (wait_q | accepted);
            cnt_q  <= (~active | restart | accepted | done) ? '0 : cnt_q + TO_W'(1);
        end
    end
endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands register read/write commands into the I2C byte driver handshake.
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int TO_W = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       drv_ena,
    output logic       drv_rw,
    output logic [7:0] drv_data_wr,
    output logic       drv_start_transfer,
    output logic       drv_stop_transfer,
    output logic       drv_r_start,
    input  logic       drv_ready,
    input  logic       drv_busy,
    input  logic       drv_ack_err,
    input  logic [7:0] drv_data_rd
);
    state_t state_q, state_d;
    logic rd_q, nack_q, to_q, last, byte_phase;
    logic [6:0] dev_q;
    logic [7:0] reg_q, wdata_q, rdata_q, cur_byte;
    logic [2:0] idx_q;
    logic [1:0] kind;
    logic hs_active, hs_req, hs_accepted, hs_done, hs_timeout;

    assign kind      = item_kind(rd_q, idx_q);
    assign last      = idx_q == (rd_q ? 3'd4 : 3'd2);
    assign cur_byte  = idx_q == 3'd0 ? {dev_q, DIR_WR} : idx_q == 3'd1 ? reg_q :
                       idx_q == 3'd2 ? wdata_q : idx_q == 3'd3 ? {dev_q, DIR_RD} : 8'h00;
    assign hs_active = state_q inside {S_OPEN, S_SEND, S_RSTART, S_WAIT_DONE, S_CLOSE};

    i2c_step_handshake #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_hs (
        .clk(clk), .rst(rst), .active(hs_active), .restart(state_d != state_q),
        .drv_busy(drv_busy), .drv_ready(drv_ready), .req(hs_req),
        .accepted(hs_accepted), .done(hs_done), .timeout(hs_timeout)
    );

    always_comb begin
        state_d = state_q;
        if (hs_timeout) state_d = S_RESP;
        else case (state_q)
            S_IDLE:              if (cmd_valid) state_d = S_OPEN;
            S_OPEN:              if (hs_done) state_d = S_SEND;
            S_SEND, S_RSTART:    if (hs_accepted) state_d = S_WAIT_DONE;
            S_WAIT_DONE:         if (hs_done) state_d = ((drv_ack_err && kind != ITEM_RDBYTE) || last) ? S_CLOSE :
                                                        item_kind(rd_q, idx_q + 3'd1) == ITEM_RSTART ? S_RSTART : S_SEND;
            S_CLOSE:             if (hs_done) state_d = S_RESP;
            default:             state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            nack_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid) begin
                rd_q    <= cmd_rd;
                dev_q   <= cmd_dev;
                reg_q   <= cmd_reg;
                wdata_q <= cmd_wdata;
                rdata_q <= '0;
                idx_q   <= '0;
                nack_q  <= 1'b0;
                to_q    <= 1'b0;
            end
            if (hs_timeout) to_q <= 1'b1;
            if (state_q == S_WAIT_DONE && hs_done) begin
                if (drv_ack_err && kind != ITEM_RDBYTE) nack_q <= 1'b1;
                if (kind == ITEM_RDBYTE) rdata_q <= drv_data_rd;
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // ena stays up across every byte so the driver never re-STARTs mid-transaction
    assign byte_phase         = (state_q inside {S_SEND, S_WAIT_DONE}) && kind != ITEM_RSTART;
    assign cmd_ready          = state_q == S_IDLE;
    assign drv_ena            = state_q inside {S_OPEN, S_SEND, S_RSTART, S_WAIT_DONE};
    assign drv_start_transfer = state_q == S_SEND;
    assign drv_r_start        = state_q == S_RSTART;
    assign drv_stop_transfer  = state_q == S_CLOSE && hs_req;
    assign drv_rw             = byte_phase && kind == ITEM_RDBYTE;
    assign drv_data_wr        = (byte_phase && kind == ITEM_BYTE) ? cur_byte : 8'h00;
    assign rsp_valid          = state_q == S_RESP;
    assign rsp_nack           = rsp_valid & nack_q & ~to_q;
    assign rsp_timeout        = rsp_valid & to_q;
    assign rsp_rdata          = (rsp_valid & ~nack_q & ~to_q) ? rdata_q : 8'h00;
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: behavioural byte-driver model plus event/response scoreboards.
module tb_i2c_reg_sequencer;
    localparam logic [6:0] SLAVE = 7'h1E;
    localparam int EV_START = 32'h100, EV_SR = 32'h200, EV_STOP = 32'h300, EV_READ = 32'h400;

    typedef struct {
        bit rd; bit [6:0] dev; bit [7:0] rg; bit [7:0] wd; bit [7:0] srd;
        bit nack; bit [7:0] rdata;
    } vec_t;
    typedef struct {bit nack; bit to; bit [7:0] rdata;} rsp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_rd = 1'b0;
    logic [6:0] cmd_dev = '0;
    logic [7:0] cmd_reg = '0, cmd_wdata = '0;
    logic cmd_ready, rsp_valid, rsp_nack, rsp_timeout;
    logic [7:0] rsp_rdata, drv_data_wr;
    logic drv_ena, drv_rw, drv_start_transfer, drv_stop_transfer, drv_r_start;
    logic drv_ready, drv_busy, drv_ack_err;
    logic [7:0] drv_data_rd;

    int exp_ev[$];
    rsp_t exp_rsp[$];
    int n_cmp = 0, n_bad = 0, rsp_cnt = 0;
    bit hang = 1'b0;
    logic [7:0] slave_rd = 8'h00;
    vec_t vecs[6];

    i2c_reg_sequencer #(.TIMEOUT_CYC(1000), .TO_W(10)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout), .drv_ena(drv_ena),
        .drv_rw(drv_rw), .drv_data_wr(drv_data_wr), .drv_start_transfer(drv_start_transfer),
        .drv_stop_transfer(drv_stop_transfer), .drv_r_start(drv_r_start), .drv_ready(drv_ready),
        .drv_busy(drv_busy), .drv_ack_err(drv_ack_err), .drv_data_rd(drv_data_rd)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void log_ev(input int ev);
        if (exp_ev.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus event: got %0h expected none", ev);
        end else check("bus event", 32'(ev), 32'(exp_ev.pop_front()));
    endfunction

    function automatic void push_exp(input vec_t v);
        exp_ev.push_back(EV_START);
        exp_ev.push_back(int'({v.dev, 1'b0}));
        if (v.dev == SLAVE) begin
            exp_ev.push_back(int'(v.rg));
            if (v.rd) begin
                exp_ev.push_back(EV_SR);
                exp_ev.push_back(int'({v.dev, 1'b1}));
                exp_ev.push_back(EV_READ);
            end else exp_ev.push_back(int'(v.wd));
        end
        exp_ev.push_back(EV_STOP);
        exp_rsp.push_back('{v.nack, 1'b0, v.rdata});
    endfunction

    task automatic set_cmd(input vec_t v);
        cmd_rd = v.rd; cmd_dev = v.dev; cmd_reg = v.rg; cmd_wdata = v.wd;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_ready before cmd", 32'(cmd_ready), 1);
    endtask

    task automatic run_cmd(input vec_t v);
        bit got = 0;
        slave_rd = v.srd;
        push_exp(v);
        wait_ready();
        set_cmd(v);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1; break; end
        end
        check("rsp seen", 32'(got), 1);
        @(negedge clk);
        check("cmd_ready after rsp", 32'(cmd_ready), 1);
        check("bus events left", 32'(exp_ev.size()), 0);
        if (!got) begin exp_ev.delete(); exp_rsp.delete(); end
    endtask

    // byte-driver model: every operation takes 3 cycles of busy, logged at completion
    initial begin
        int busy_cnt, pend_ev;
        bit bus_open, addr_phase, ack_next, go;
        busy_cnt = 0; pend_ev = 0; bus_open = 0; addr_phase = 0; ack_next = 0;
        drv_busy = 1'b0; drv_ready = 1'b1; drv_ack_err = 1'b0; drv_data_rd = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                drv_busy = 1'b0; drv_ready = 1'b1; drv_ack_err = 1'b0;
                bus_open = 0; busy_cnt = 0;
            end else if (hang) begin
                drv_busy = 1'b0; drv_ready = 1'b1;
            end else if (drv_busy) begin
                if (busy_cnt > 1) busy_cnt--;
                else begin
                    drv_busy = 1'b0; drv_ready = 1'b1; drv_ack_err = ack_next;
                    if (pend_ev == EV_READ) drv_data_rd = slave_rd;
                    log_ev(pend_ev);
                end
            end else begin
                go = 1;
                if (!bus_open && drv_ena) begin
                    pend_ev = EV_START; bus_open = 1; addr_phase = 1; ack_next = 0; drv_ack_err = 1'b0;
                end else if (bus_open && drv_start_transfer && drv_rw) pend_ev = EV_READ;
                else if (bus_open && drv_start_transfer) begin
                    pend_ev = int'(drv_data_wr);
                    if (addr_phase) ack_next = drv_data_wr[7:1] != SLAVE;
                    addr_phase = 0;
                end else if (bus_open && drv_r_start) begin
                    pend_ev = EV_SR; addr_phase = 1; ack_next = 0;
                end else if (bus_open && drv_stop_transfer) begin
                    pend_ev = EV_STOP; bus_open = 0;
                end else go = 0;
                if (go) begin drv_busy = 1'b1; drv_ready = 1'b0; busy_cnt = 3; end
            end
        end
    end

    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cnt++;
                if (exp_rsp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_valid: got 1 expected 0");
                end else begin
                    r = exp_rsp.pop_front();
                    check("rsp_nack", 32'(rsp_nack), 32'(r.nack));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(r.to));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, base;
        bit found;
        vec_t s[4];
        vecs[0] = '{0, 7'h1E, 8'h02, 8'h00, 8'h00, 0, 8'h00};
        vecs[1] = '{1, 7'h1E, 8'h0A, 8'h00, 8'h48, 0, 8'h48};
        vecs[2] = '{0, 7'h50, 8'h02, 8'h99, 8'h00, 1, 8'h00};
        vecs[3] = '{1, 7'h50, 8'h0A, 8'h00, 8'h77, 1, 8'h00};
        vecs[4] = '{0, 7'h1E, 8'h7F, 8'hA5, 8'h00, 0, 8'h00};
        vecs[5] = '{1, 7'h1E, 8'hFF, 8'h00, 8'hC3, 0, 8'hC3};
        repeat (3) @(negedge clk);
        check("reset drv outputs", 32'({drv_ena, drv_rw, drv_data_wr, drv_start_transfer,
              drv_stop_transfer, drv_r_start}), 0);
        check("reset rsp outputs", 32'({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout}), 0);
        check("reset cmd_ready", 32'(cmd_ready), 1);
        rst = 1'b0;
        foreach (vecs[i]) run_cmd(vecs[i]);

        // driver never goes busy: the OPEN step must time out
        hang = 1'b1;
        exp_rsp.push_back('{1'b0, 1'b1, 8'h00});
        wait_ready();
        set_cmd(vecs[0]);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin n = i; break; end
        end
        check("timeout latency in range", 32'(n >= 999 && n <= 1003), 1);
        check("drv idle on timeout", 32'({drv_ena, drv_rw, drv_data_wr, drv_start_transfer,
              drv_stop_transfer, drv_r_start}), 0);
        @(negedge clk);
        hang = 1'b0;
        check("cmd_ready after timeout", 32'(cmd_ready), 1);

        // reset while the write data byte is being requested
        exp_ev.push_back(EV_START);
        exp_ev.push_back(32'h3C);
        exp_ev.push_back(32'h03);
        wait_ready();
        cmd_rd = 1'b0; cmd_dev = SLAVE; cmd_reg = 8'h03; cmd_wdata = 8'h55;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drv_start_transfer && drv_data_wr == 8'h55) begin found = 1; break; end
        end
        check("reached data byte", 32'(found), 1);
        rst = 1'b1;
        #1;
        check("mid rst drv outputs", 32'({drv_ena, drv_rw, drv_data_wr, drv_start_transfer,
              drv_stop_transfer, drv_r_start}), 0);
        check("mid rst rsp outputs", 32'({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout}), 0);
        check("mid rst cmd_ready", 32'(cmd_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("aborted bus events left", 32'(exp_ev.size()), 0);
        exp_ev.delete();
        run_cmd(vecs[1]);

        // cmd_valid held high with alternating commands
        s[0] = '{0, 7'h1E, 8'h10, 8'h11, 8'h5A, 0, 8'h00};
        s[1] = '{1, 7'h1E, 8'h20, 8'h00, 8'h5A, 0, 8'h5A};
        s[2] = '{0, 7'h1E, 8'h30, 8'h33, 8'h5A, 0, 8'h00};
        s[3] = '{1, 7'h1E, 8'h40, 8'h00, 8'h5A, 0, 8'h5A};
        slave_rd = 8'h5A;
        base = rsp_cnt;
        k = 0;
        wait_ready();
        set_cmd(s[0]);
        cmd_valid = 1'b1;
        for (int t = 0; t < 3000 && k < 4; t++) begin
            if (cmd_ready) begin
                push_exp(s[k]);
                k++;
                @(negedge clk);
                if (k < 4) set_cmd(s[k]);
                else cmd_valid = 1'b0;
            end else @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (rsp_cnt - base >= 4 && exp_rsp.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        check("stream accepted", 32'(k), 4);
        check("stream rsp count", 32'(rsp_cnt - base), 4);
        check("stream bus events left", 32'(exp_ev.size()), 0);
        check("rsp queue drained", 32'(exp_rsp.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
